hazard_ctrl: RTL and testbench

- Pipeline hazard controller for the 5-stage MIPS pipeline; sits beside the ID stage.
- Produces the `stallSignal` and `nonSeq` controls consumed by the ID/EX pipeline register. It also produces PC and IF/ID write enables and the IF/ID flush.
- Decodes the ID, EX and MEM stage instructions to detect RAW hazards and inserts a deterministic number of bubbles.
- Squashes wrong-path instructions on a branch taken in EX or a jump in ID, and keeps hazard performance counters.

---
 rtl/mips_pkg.sv | 51 +++++
 rtl/instr_regs_dec.sv | 56 +++++
 rtl/hazard_ctrl.sv | 161 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcodes, instruction field positions,
// hazard FSM state encoding.
package mips_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned REM_W   = 2;

    localparam int unsigned OP_MSB = 31;
    localparam int unsigned OP_LSB = 26;
    localparam int unsigned RS_MSB = 25;
    localparam int unsigned RS_LSB = 21;
    localparam int unsigned RT_MSB = 20;
    localparam int unsigned RT_LSB = 16;
    localparam int unsigned RD_MSB = 15;
    localparam int unsigned RD_LSB = 11;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OP_W-1:0] OP_ADDIU = 6'h09;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
    localparam logic [OP_W-1:0] OP_XORI  = 6'h0E;
    localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

    localparam logic [REG_W-1:0] REG_RA = 5'd31;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } hz_state_e;

    // I-type ALU ops write rt and read rs.
    function automatic logic is_itype_alu(input logic [OP_W-1:0] op);
        logic r;
        r = 1'b0;
        case (op)
            OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/instr_regs_dec.sv
// Combinational register-usage decode of one instruction: destination,
// which source fields are read, and load/jump class.
module instr_regs_dec
    import mips_pkg::*;
(
    input  logic [INSTR_W-1:0] instr,
    output logic [REG_W-1:0]   dest,
    output logic               dest_valid,
    output logic               src_rs_used,
    output logic               src_rt_used,
    output logic               is_load,
    output logic               is_jump
);

    logic [OP_W-1:0]  op;
    logic [REG_W-1:0] dest_raw;
    logic             unused_imm;

    assign op         = instr[OP_MSB:OP_LSB];
    assign unused_imm = ^instr[RD_LSB-1:0];

    always_comb begin
        dest_raw    = '0;
        src_rs_used = 1'b0;
        src_rt_used = 1'b0;
        case (op)
            OP_RTYPE: begin
                dest_raw    = instr[RD_MSB:RD_LSB];
                src_rs_used = 1'b1;
                src_rt_used = 1'b1;
            end
            OP_SW, OP_BEQ, OP_BNE: begin
                src_rs_used = 1'b1;
                src_rt_used = 1'b1;
            end
            OP_LW: begin
                dest_raw    = instr[RT_MSB:RT_LSB];
                src_rs_used = 1'b1;
            end
            OP_JAL: dest_raw = REG_RA;
            default: begin
                if (is_itype_alu(op)) begin
                    dest_raw    = instr[RT_MSB:RT_LSB];
                    src_rs_used = 1'b1;
                end
            end
        endcase
    end

    // Writes to $0 are discarded, so they never create a dependency.
    assign dest       = dest_raw;
    assign dest_valid = (dest_raw != '0);
    assign is_load    = (op == OP_LW);
    assign is_jump    = (op == OP_J) || (op == OP_JAL);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller beside ID: RAW stall insertion, wrong-path
// squash on taken branch / jump, and hazard performance counters.
module hazard_ctrl
    import mips_pkg::*;
#(
    parameter bit          FORWARDING = 1'b1,
    parameter int unsigned CNT_W      = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] instr_id,
    input  logic [INSTR_W-1:0] instr_ex,
    input  logic [INSTR_W-1:0] instr_mem,
    input  logic               br_taken_ex,
    output logic               stallSignal,
    output logic               nonSeq,
    output logic               pc_we,
    output logic               if_id_we,
    output logic               if_id_flush,
    output logic [CNT_W-1:0]   stall_cycles,
    output logic [CNT_W-1:0]   flush_events
);

    logic [REG_W-1:0] id_dest, ex_dest, mem_dest;
    logic id_dest_valid, ex_dest_valid, mem_dest_valid;
    logic id_rs_used, id_rt_used, ex_rs_used, ex_rt_used, mem_rs_used, mem_rt_used;
    logic id_is_load, ex_is_load, mem_is_load;
    logic id_is_jump, ex_is_jump, mem_is_jump;
    logic unused_dec;

    instr_regs_dec u_dec_id (
        .instr(instr_id), .dest(id_dest), .dest_valid(id_dest_valid),
        .src_rs_used(id_rs_used), .src_rt_used(id_rt_used),
        .is_load(id_is_load), .is_jump(id_is_jump)
    );

    instr_regs_dec u_dec_ex (
        .instr(instr_ex), .dest(ex_dest), .dest_valid(ex_dest_valid),
        .src_rs_used(ex_rs_used), .src_rt_used(ex_rt_used),
        .is_load(ex_is_load), .is_jump(ex_is_jump)
    );

    instr_regs_dec u_dec_mem (
        .instr(instr_mem), .dest(mem_dest), .dest_valid(mem_dest_valid),
        .src_rs_used(mem_rs_used), .src_rt_used(mem_rt_used),
        .is_load(mem_is_load), .is_jump(mem_is_jump)
    );

    assign unused_dec = ^{id_dest, id_dest_valid, id_is_load, ex_rs_used, ex_rt_used,
                          ex_is_jump, mem_rs_used, mem_rt_used, mem_is_load, mem_is_jump};

    logic [REG_W-1:0] id_rs, id_rt;
    logic             hit_ex_c, hit_mem_c;
    logic [REM_W-1:0] need_c;

    assign id_rs = instr_id[RS_MSB:RS_LSB];
    assign id_rt = instr_id[RT_MSB:RT_LSB];

    // Required bubble count for the instruction currently in ID.
    always_comb begin
        hit_ex_c  = ex_dest_valid && ((id_rs_used && (id_rs == ex_dest)) ||
                                      (id_rt_used && (id_rt == ex_dest)));
        hit_mem_c = mem_dest_valid && ((id_rs_used && (id_rs == mem_dest)) ||
                                       (id_rt_used && (id_rt == mem_dest)));
        need_c = '0;
        if (FORWARDING) begin
            if (ex_is_load && hit_ex_c) need_c = REM_W'(1);
        end else begin
            if (hit_ex_c)       need_c = REM_W'(2);
            else if (hit_mem_c) need_c = REM_W'(1);
        end
    end

    hz_state_e        state_q, state_d;
    logic [REM_W-1:0] rem_q, rem_d;
    logic             stall_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        if (br_taken_ex) begin
            state_d = RUN;
            rem_d   = '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (need_c == REM_W'(2)) begin
                        state_d = STALL;
                        rem_d   = REM_W'(1);
                    end
                end
                STALL: begin
                    rem_d = rem_q - REM_W'(1);
                    if (rem_q <= REM_W'(1)) begin
                        state_d = RUN;
                        rem_d   = '0;
                    end
                end
                default: begin
                    state_d = RUN;
                    rem_d   = '0;
                end
            endcase
        end
    end

    // Held STALL ignores fresh hazard detection; a taken branch beats any stall.
    assign stall_c = !br_taken_ex && ((state_q == STALL) || (need_c != '0));

    always_comb begin
        stallSignal = 1'b0;
        nonSeq      = 1'b0;
        pc_we       = 1'b1;
        if_id_we    = 1'b1;
        if_id_flush = 1'b0;
        if (!rst) begin
            if (br_taken_ex) begin
                nonSeq      = 1'b1;
                if_id_flush = 1'b1;
            end else if (stall_c) begin
                stallSignal = 1'b1;
                pc_we       = 1'b0;
                if_id_we    = 1'b0;
            end else if (id_is_jump) begin
                if_id_flush = 1'b1;
            end
        end
    end

    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_events_q, flush_events_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q + CNT_W'(stall_c);
        flush_events_d = flush_events_q + CNT_W'(br_taken_ex);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: both FORWARDING variants driven in parallel, checked
// every cycle against a countdown model plus directed scenarios.
module tb_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] iid, iex, imem;
    logic        br;

    logic        st0, ns0, pc0, we0, fl0;
    logic        st1, ns1, pc1, we1, fl1;
    logic [31:0] sc0, fe0, sc1, fe1;

    hazard_ctrl #(.FORWARDING(1'b0), .CNT_W(32)) u0 (
        .clk(clk), .rst(rst), .instr_id(iid), .instr_ex(iex), .instr_mem(imem),
        .br_taken_ex(br), .stallSignal(st0), .nonSeq(ns0), .pc_we(pc0),
        .if_id_we(we0), .if_id_flush(fl0), .stall_cycles(sc0), .flush_events(fe0)
    );

    hazard_ctrl #(.FORWARDING(1'b1), .CNT_W(32)) u1 (
        .clk(clk), .rst(rst), .instr_id(iid), .instr_ex(iex), .instr_mem(imem),
        .br_taken_ex(br), .stallSignal(st1), .nonSeq(ns1), .pc_we(pc1),
        .if_id_we(we1), .if_id_flush(fl1), .stall_cycles(sc1), .flush_events(fe1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int dest_of(input logic [31:0] i);
        logic [5:0] op;
        int r;
        op = i[31:26];
        r  = 0;
        case (op)
            6'h00: r = int'(i[15:11]);
            6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23: r = int'(i[20:16]);
            6'h03: r = 31;
            default: r = 0;
        endcase
        return (r == 0) ? -1 : r;
    endfunction

    function automatic bit reads(input logic [31:0] i, input int r);
        logic [5:0] op;
        int rs, rt;
        op = i[31:26];
        rs = int'(i[25:21]);
        rt = int'(i[20:16]);
        if (r < 0) return 1'b0;
        case (op)
            6'h00, 6'h2B, 6'h04, 6'h05: return (rs == r) || (rt == r);
            6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23: return rs == r;
            default: return 1'b0;
        endcase
    endfunction

    int          pend [2] = '{0, 0};
    logic [31:0] scnt [2] = '{32'd0, 32'd0};
    logic [31:0] fcnt [2] = '{32'd0, 32'd0};

    int          m_n;
    bit          m_st;
    logic [4:0]  m_exp;
    logic [4:0]  m_act;
    logic [31:0] m_sc, m_fe;
    logic [5:0]  m_op;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            m_op = iex[31:26];
            if (k == 1)
                m_n = (m_op == 6'h23 && reads(iid, dest_of(iex))) ? 1 : 0;
            else
                m_n = reads(iid, dest_of(iex)) ? 2 : (reads(iid, dest_of(imem)) ? 1 : 0);
            m_st  = 1'b0;
            m_exp = 5'b00110;
            if (rst) begin
                m_exp = 5'b00110;
            end else if (br) begin
                m_exp = 5'b01111;
            end else if (pend[k] > 0 || m_n > 0) begin
                m_exp = 5'b10000;
                m_st  = 1'b1;
            end else if (iid[31:26] == 6'h02 || iid[31:26] == 6'h03) begin
                m_exp = 5'b00111;
            end
            m_act = (k == 0) ? {st0, ns0, pc0, we0, fl0} : {st1, ns1, pc1, we1, fl1};
            m_sc  = (k == 0) ? sc0 : sc1;
            m_fe  = (k == 0) ? fe0 : fe1;
            check($sformatf("ctl[fw%0d]", k), 32'(m_act), 32'(m_exp));
            check($sformatf("stall_cycles[fw%0d]", k), m_sc, scnt[k]);
            check($sformatf("flush_events[fw%0d]", k), m_fe, fcnt[k]);
            if (rst) begin
                pend[k] = 0;
                scnt[k] = 0;
                fcnt[k] = 0;
            end else begin
                if (br) begin
                    pend[k] = 0;
                    fcnt[k] = fcnt[k] + 1;
                end else if (pend[k] > 0) begin
                    pend[k] = pend[k] - 1;
                end else if (m_n > 0) begin
                    pend[k] = m_n - 1;
                end
                if (m_st) scnt[k] = scnt[k] + 1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic set_in(input logic [31:0] d_id, input logic [31:0] d_ex,
                          input logic [31:0] d_mem, input logic d_br);
        iid  = d_id;
        iex  = d_ex;
        imem = d_mem;
        br   = d_br;
    endtask

    task automatic do_reset();
        cyc();
        rst = 1'b1;
        set_in(32'h0, 32'h0, 32'h0, 1'b0);
        cyc();
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] ops [12];
        ops = '{6'h00, 6'h00, 6'h08, 6'h09, 6'h0C, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03};
        if ($urandom_range(0, 15) == 0)
            return {6'h3F, 26'($urandom)};
        return {ops[$urandom_range(0, 11)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 11'($urandom)};
    endfunction

    initial begin
        rst = 1'b1;
        set_in(32'h0, 32'h0, 32'h0, 1'b0);
        cyc();
        cyc();
        rst = 1'b0;

        // load-use with forwarding: single bubble
        set_in(32'h01084820, 32'h8C080000, 32'h0, 1'b0);
        sample();
        check("lu_stall", 32'(st1), 32'd1);
        check("lu_pc_we", 32'(pc1), 32'd0);
        check("lu_if_id_we", 32'(we1), 32'd0);
        cyc();
        set_in(32'h01084820, 32'h0, 32'h8C080000, 1'b0);
        sample();
        check("lu_after_stall", 32'(st1), 32'd0);
        check("lu_after_pc_we", 32'(pc1), 32'd1);
        check("lu_stall_cycles", sc1, 32'd1);

        // $0 destination is never a hazard
        do_reset();
        set_in(32'h00004820, 32'h8C000000, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            sample();
            check("r0_stall_fw1", 32'(st1), 32'd0);
            check("r0_stall_fw0", 32'(st0), 32'd0);
            cyc();
        end

        // RAW without forwarding: two held bubbles, then mem-only single bubble
        do_reset();
        set_in(32'hAC080000, 32'h20080001, 32'h0, 1'b0);
        sample();
        check("raw_c1", 32'(st0), 32'd1);
        cyc();
        set_in(32'hAC080000, 32'h0, 32'h20080001, 1'b0);
        sample();
        check("raw_c2", 32'(st0), 32'd1);
        cyc();
        set_in(32'hAC080000, 32'h0, 32'h0, 1'b0);
        sample();
        check("raw_done", 32'(st0), 32'd0);
        check("raw_stall_cycles", sc0, 32'd2);
        cyc();
        set_in(32'hAC080000, 32'h0, 32'h20080001, 1'b0);
        sample();
        check("mem_dep_stall", 32'(st0), 32'd1);
        cyc();
        set_in(32'hAC080000, 32'h0, 32'h0, 1'b0);
        sample();
        check("mem_dep_done", 32'(st0), 32'd0);
        check("mem_dep_stall_cycles", sc0, 32'd3);

        // taken branch aborts a pending stall
        do_reset();
        set_in(32'hAC080000, 32'h20080001, 32'h0, 1'b0);
        sample();
        check("brs_c1", 32'(st0), 32'd1);
        cyc();
        set_in(32'hAC080000, 32'h0, 32'h20080001, 1'b1);
        sample();
        check("brs_ctl", 32'({st0, ns0, pc0, fl0}), 32'b0111);
        cyc();
        set_in(32'h0, 32'h0, 32'h0, 1'b0);
        sample();
        check("brs_after_stall", 32'(st0), 32'd0);
        check("brs_flush_events", fe0, 32'd1);
        check("brs_stall_cycles", sc0, 32'd1);

        // jump in ID
        do_reset();
        set_in(32'h08000010, 32'h0, 32'h0, 1'b0);
        sample();
        check("jmp_ctl", 32'({fl1, ns1, st1, pc1}), 32'b1001);
        cyc();
        set_in(32'h0, 32'h0, 32'h0, 1'b0);
        sample();
        check("jmp_one_cycle", 32'(fl1), 32'd0);

        // reset in the middle of a 2-cycle stall
        do_reset();
        set_in(32'hAC080000, 32'h20080001, 32'h0, 1'b0);
        sample();
        check("rst_mid_c1", 32'(st0), 32'd1);
        cyc();
        rst = 1'b1;
        sample();
        check("rst_mid_forced", 32'({st0, pc0, we0}), 32'b011);
        cyc();
        rst = 1'b0;
        set_in(32'hAC080000, 32'h0, 32'h0, 1'b0);
        sample();
        check("rst_no_residual", 32'(st0), 32'd0);
        check("rst_stall_cycles", sc0, 32'd0);
        check("rst_flush_events", fe0, 32'd0);

        // randomized traffic, checked by the per-cycle model
        for (int i = 0; i < 3000; i++) begin
            cyc();
            rst  = ($urandom_range(0, 49) == 0);
            br   = ($urandom_range(0, 9) == 0);
            iid  = rand_instr();
            iex  = rand_instr();
            imem = rand_instr();
        end
        cyc();
        sample();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
